// File: rtl/add_subt_pkg.sv
// Shared types and constants for the add/subtract responder used by the CORDIC datapath.
package add_subt_pkg;

    localparam int W_DEF = 32;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPER  = 2'd1,
        CHECK = 2'd2,
        READY = 2'd3
    } state_e;

    // Saturation limits for a w-bit two's complement value, right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] max_pos(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] min_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sat_add_subt_core.sv
// Combinational W+1-bit add/subtract and the overflow/underflow/saturation decode of a registered sum.
module sat_add_subt_core
    import add_subt_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W:0]   sum,
    input  logic [W:0]   sum_in,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf
);

    localparam logic [MAX_W-1:0] MAX_POS = max_pos(W);
    localparam logic [MAX_W-1:0] MIN_NEG = min_neg(W);
    localparam logic [W:0]       ONE     = (W+1)'(1);

    logic [W:0] a_ext;
    logic [W:0] b_ext;
    logic [W:0] b_op;

    // One guard bit makes the true result always representable.
    assign a_ext = {a[W-1], a};
    assign b_ext = {b[W-1], b};
    assign b_op  = sub ? (~b_ext + ONE) : b_ext;
    assign sum   = a_ext + b_op;

    assign ovf = (sum_in[W:W-1] == 2'b01);
    assign unf = (sum_in[W:W-1] == 2'b10);

    always_comb begin
        result = sum_in[W-1:0];
        if (SAT) begin
            if (ovf)      result = MAX_POS[W-1:0];
            else if (unf) result = MIN_NEG[W-1:0];
        end
    end

endmodule

// File: rtl/add_subt_resp_unit.sv
// Responder side of the beg/ready/ack add-subtract handshake: capture, add, check, hold until acked.
module add_subt_resp_unit
    import add_subt_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         beg_add_subt,
    input  logic         ack_add_subt,
    input  logic         add_subt,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    output logic         ready_add_subt,
    output logic [W-1:0] add_subt_result,
    output logic         overflow_flag,
    output logic         underflow_flag
);

    state_e       state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         sub_q, sub_d;
    logic [W:0]   sum_q, sum_d;
    logic [W-1:0] res_q, res_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         rdy_q, rdy_d;

    logic [W:0]   sum_c;
    logic [W-1:0] res_c;
    logic         ovf_c;
    logic         unf_c;

    sat_add_subt_core #(.W(W), .SAT(SAT)) u_core (
        .a      (x_q),
        .b      (y_q),
        .sub    (sub_q),
        .sum    (sum_c),
        .sum_in (sum_q),
        .result (res_c),
        .ovf    (ovf_c),
        .unf    (unf_c)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: if (beg_add_subt) begin
                x_d     = Data_X;
                y_d     = Data_Y;
                sub_d   = add_subt;
                state_d = OPER;
            end
            OPER: begin
                sum_d   = sum_c;
                state_d = CHECK;
            end
            CHECK: begin
                res_d   = res_c;
                ovf_d   = ovf_c;
                unf_d   = unf_c;
                rdy_d   = 1'b1;
                state_d = READY;
            end
            // Result and flags stay put after ack until the next CHECK overwrites them.
            READY: if (ack_add_subt) begin
                rdy_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ready_add_subt  = rdy_q;
    assign add_subt_result = res_q;
    assign overflow_flag   = ovf_q;
    assign underflow_flag  = unf_q;

endmodule

// File: tb/tb_add_subt_resp_unit.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; monitors check each ready rise.
module tb_add_subt_resp_unit;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        beg, ack, sub;
    logic [31:0] dx, dy;
    logic        rdy1, ovf1, unf1, rdy0, ovf0, unf0;
    logic [31:0] res1, res0;

    int vectors = 0;
    int miscompares = 0;
    exp_t q1[$];
    exp_t q0[$];

    // Hand-computed vectors: operands, op, saturated result, wrapped result, flags.
    logic [31:0] vx [8] = '{32'h0000_0005, 32'h0000_0003, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vy [8] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] vrs[8] = '{32'h0000_0008, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic [31:0] vrw[8] = '{32'h0000_0008, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h8000_0000};
    logic        vo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vu [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    add_subt_resp_unit #(.W(32), .SAT(1'b1)) u_sat (
        .clk(clk), .reset(reset), .beg_add_subt(beg), .ack_add_subt(ack), .add_subt(sub),
        .Data_X(dx), .Data_Y(dy), .ready_add_subt(rdy1), .add_subt_result(res1),
        .overflow_flag(ovf1), .underflow_flag(unf1));

    add_subt_resp_unit #(.W(32), .SAT(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .beg_add_subt(beg), .ack_add_subt(ack), .add_subt(sub),
        .Data_X(dx), .Data_Y(dy), .ready_add_subt(rdy0), .add_subt_result(res0),
        .overflow_flag(ovf0), .underflow_flag(unf0));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k);
        dx  = vx[k];
        dy  = vy[k];
        sub = vs[k];
        q1.push_back('{vrs[k], vo[k], vu[k]});
        q0.push_back('{vrw[k], vo[k], vu[k]});
    endtask

    // Operands are scrambled right after capture; the result must not depend on them.
    task automatic capture();
        beg = 1'b1;
        tick();
        beg = 1'b0;
        dx  = $urandom;
        dy  = $urandom;
        sub = ~sub;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!rdy1 && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_ready_wrap"}, 64'(rdy0), 64'd1);
    endtask

    task automatic ack_it(input string nm);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({nm, "_ready_after_ack"}, 64'(rdy1), 64'd0);
    endtask

    logic rdy1_prev = 1'b0;
    logic rdy0_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rdy1 && !rdy1_prev) begin
            if (q1.size() == 0) chk("sat_unexpected_ready", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("sat_result", 64'(res1), 64'(e.res));
                chk("sat_ovf", 64'(ovf1), 64'(e.ovf));
                chk("sat_unf", 64'(unf1), 64'(e.unf));
            end
        end
        rdy1_prev = rdy1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rdy0 && !rdy0_prev) begin
            if (q0.size() == 0) chk("wrap_unexpected_ready", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                chk("wrap_result", 64'(res0), 64'(e.res));
                chk("wrap_ovf", 64'(ovf0), 64'(e.ovf));
                chk("wrap_unf", 64'(unf0), 64'(e.unf));
            end
        end
        rdy0_prev = rdy0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; beg = 1'b0; ack = 1'b0; sub = 1'b0; dx = '0; dy = '0;
        tick(); tick();
        chk("reset_ready", 64'(rdy1), 64'd0);
        chk("reset_result", 64'({res1, res0}), 64'd0);
        chk("reset_flags", 64'({ovf1, unf1, ovf0, unf0}), 64'd0);
        reset = 1'b0;
        tick();

        // ack while idle must not disturb anything
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0;
        chk("ack_idle_ready", 64'(rdy1), 64'd0);

        // basic add with a long ack delay
        load(0);
        capture();
        wait_ready("v0");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("v0_hold_ready", 64'(rdy1), 64'd1);
            chk("v0_hold_result", 64'(res1), 64'h8);
        end
        ack_it("v0");

        // beg held high through OPER/CHECK/READY is ignored
        load(1);
        capture();
        beg = 1'b1;
        wait_ready("v1");
        tick();
        beg = 1'b0;
        chk("v1_beg_in_ready", 64'(rdy1), 64'd1);
        ack_it("v1");
        for (int i = 0; i < 4; i++) tick();
        chk("v1_no_extra_ready", 64'(rdy1), 64'd0);
        chk("v1_result_held", 64'(res1), 64'hFFFF_FFFE);

        for (int k = 2; k < 7; k++) begin
            load(k);
            capture();
            wait_ready($sformatf("v%0d", k));
            ack_it($sformatf("v%0d", k));
        end

        // beg and ack together in READY: ack wins, new capture on the following edge
        load(0);
        capture();
        wait_ready("v0b");
        load(7);
        beg = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("begack_ready_low", 64'(rdy1), 64'd0);
        capture();
        wait_ready("v7");
        ack_it("v7");

        // reset during OPER aborts the operation and clears outputs immediately
        dx = 32'h5; dy = 32'h3; sub = 1'b0;
        beg = 1'b1;
        tick();
        beg = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 64'({rdy1, rdy0}), 64'd0);
        chk("rst_mid_result_sat", 64'(res1), 64'd0);
        chk("rst_mid_result_wrap", 64'(res0), 64'd0);
        chk("rst_mid_flags", 64'({ovf1, unf1, ovf0, unf0}), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_no_ready", 64'(rdy1), 64'd0);

        chk("sat_queue_drained", 64'(q1.size()), 64'd0);
        chk("wrap_queue_drained", 64'(q0.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
